// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: owns the PC, issues one imem read at a time, holds the result for decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rerr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus_4,
    output logic        fetch_err,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        misaligned;
    logic        accept;

    assign misaligned     = (pc[1:0] != 2'b00);
    assign imem_req_valid = (state == S_REQ) && !rst && !misaligned;
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign inst_valid     = (state == S_HOLD);
    assign inst_pc_plus_4 = inst_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            inst      <= 32'd0;
            inst_pc   <= 32'd0;
            fetch_err <= 1'b0;
            // A request still in flight must have its response swallowed after reset.
            if (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rvalid)
                state <= S_DRAIN;
            else
                state <= S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (flush) begin
                        pc <= flush_pc;
                        if (accept)
                            state <= S_DRAIN;
                    end else if (misaligned) begin
                        inst      <= 32'd0;
                        fetch_err <= 1'b1;
                        inst_pc   <= pc;
                        state     <= S_HOLD;
                    end else if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        pc    <= flush_pc;
                        state <= imem_rvalid ? S_REQ : S_DRAIN;
                    end else if (imem_rvalid) begin
                        inst      <= imem_rerr ? 32'd0 : imem_rdata;
                        fetch_err <= imem_rerr;
                        inst_pc   <= pc;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        pc    <= flush_pc;
                        state <= S_REQ;
                    end else if (inst_ready) begin
                        pc    <= next_pc;
                        state <= S_REQ;
                    end
                end
                default: begin
                    if (flush)
                        pc <= flush_pc;
                    if (imem_rvalid)
                        state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a PC/response scoreboard
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rerr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus_4;
    logic        fetch_err;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rerr(imem_rerr),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_pc_plus_4(inst_pc_plus_4), .fetch_err(fetch_err),
        .next_pc(next_pc), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // memory model: at most one response pending, delivered after a random delay
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;

    // reference model: architectural PC and the instruction owed for it
    logic [31:0] exp_pc = RST_PC;
    logic        live = 1'b0;
    logic        have_exp = 1'b0;
    logic [31:0] exp_data = 32'd0;
    logic        exp_err = 1'b0;
    logic        prev_rst = 1'b0;
    logic        want_valid = 1'b0;
    logic        want_req = 1'b0;
    logic        want_noreq = 1'b0;
    logic [31:0] want_addr = 32'd0;
    int          idle = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_pc(input logic [31:0] base);
        logic [31:0] v;
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0)      v = 32'hFFFF_FFFC;
        else if (sel == 1) v = ($urandom & 32'h0000_FFFC) | 32'd2;
        else if (sel <= 4) v = $urandom & 32'h0000_FFFC;
        else               v = base + 32'd4;
        return v;
    endfunction

    task automatic step(input logic r);
        logic acc, rv, fl, cons;
        logic [31:0] e_inst;
        logic        e_err;
        @(negedge clk);
        rst            = r;
        fl             = ($urandom_range(0, 19) == 0);
        flush          = fl;
        flush_pc       = pick_pc(exp_pc + 32'h40);
        inst_ready     = ($urandom_range(0, 9) < 7);
        next_pc        = pick_pc(exp_pc);
        imem_req_ready = ($urandom_range(0, 2) != 0);
        rv             = mem_busy && (mem_cnt == 0);
        imem_rvalid    = rv;
        imem_rdata     = $urandom;
        imem_rerr      = ($urandom_range(0, 7) == 0);
        #1;
        acc = imem_req_valid && imem_req_ready;

        if (prev_rst) begin
            chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
            chk("rst_inst", inst, 32'd0);
            chk("rst_inst_pc", inst_pc, 32'd0);
            chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        end
        if (want_valid)
            chk("valid_after_rvalid", {31'd0, inst_valid}, 32'd1);
        if (want_req && !r) begin
            chk("req_valid_next", {31'd0, imem_req_valid}, 32'd1);
            chk("req_addr_next", imem_addr, want_addr);
        end
        if (want_noreq && !r)
            chk("no_req_misaligned", {31'd0, imem_req_valid}, 32'd0);
        if (acc)
            chk("single_outstanding", {31'd0, mem_busy}, 32'd0);

        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_cnt  = $urandom_range(0, 3);
        end

        want_valid = 1'b0;
        want_req   = 1'b0;
        want_noreq = 1'b0;

        if (r) begin
            chk("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
            live     = 1'b0;
            have_exp = 1'b0;
            exp_pc   = RST_PC;
            prev_rst = 1'b1;
            idle     = 0;
            return;
        end
        prev_rst = 1'b0;

        if (inst_valid) begin
            idle = 0;
            if (exp_pc[1:0] != 2'b00) begin
                e_inst = 32'd0;
                e_err  = 1'b1;
            end else begin
                chk("presented_has_response", {31'd0, have_exp}, 32'd1);
                e_inst = exp_err ? 32'd0 : exp_data;
                e_err  = exp_err;
            end
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, e_inst);
            chk("fetch_err", {31'd0, fetch_err}, {31'd0, e_err});
            chk("inst_pc_plus_4", inst_pc_plus_4, exp_pc + 32'd4);
        end else begin
            idle++;
            if (idle > 200) begin
                chk("watchdog_progress", idle, 0);
                idle = 0;
            end
        end

        if (acc)
            chk("req_addr", imem_addr, exp_pc);

        if (rv) begin
            if (live && !fl) begin
                have_exp   = 1'b1;
                exp_data   = imem_rdata;
                exp_err    = imem_rerr;
                want_valid = 1'b1;
            end
            live = 1'b0;
        end

        cons = inst_valid && inst_ready;
        if (fl) begin
            exp_pc   = flush_pc;
            have_exp = 1'b0;
            live     = 1'b0;
        end else if (cons) begin
            exp_pc   = next_pc;
            have_exp = 1'b0;
            if (next_pc[1:0] == 2'b00) begin
                want_req  = 1'b1;
                want_addr = next_pc;
            end else begin
                want_noreq = 1'b1;
            end
        end else if (acc) begin
            live = 1'b1;
        end else if (imem_req_valid) begin
            want_req  = 1'b1;
            want_addr = imem_addr;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = 32'd0; inst_ready = 1'b0; next_pc = 32'd0;
        imem_req_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; imem_rerr = 1'b0;
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 6000; i++)
            step($urandom_range(0, 299) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
